gate_bist_ctrl: RTL and testbench



---
 rtl/gate_bist_ctrl.sv | 123 ++++++++++++
 tb/tb_gate_bist_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for a 2-input combinational gate: walks vectors 00..11,
// holds each for SETTLE_CYCLES, samples dut_y and accumulates mismatches.
module gate_bist_ctrl #(
    parameter logic [3:0] TRUTH         = 4'b1001,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_cnt,
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic       pass;
        logic [3:0] fail_mask;
        logic [2:0] err_cnt;
    } result_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] vec_nxt;
    result_t    res, res_nxt;
    logic       mismatch;

    assign mismatch = (dut_y != TRUTH[vec_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            vec_idx <= '0;
            res     <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            vec_idx <= vec_nxt;
            res     <= res_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vec_nxt   = vec_idx;
        res_nxt   = res;
        case (state)
            IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                    vec_nxt   = '0;
                    res_nxt   = '0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nxt    = IDLE;
                    cnt_nxt      = '0;
                    res_nxt.pass = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = SAMPLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_nxt    = IDLE;
                    cnt_nxt      = '0;
                    res_nxt.pass = 1'b0;
                end else begin
                    if (mismatch) begin
                        res_nxt.fail_mask[vec_idx] = 1'b1;
                        res_nxt.err_cnt            = res.err_cnt + 3'd1;
                    end
                    if (vec_idx == 2'd3) begin
                        // pass must reflect the final vector's compare too
                        state_nxt    = DONE;
                        res_nxt.pass = (res_nxt.err_cnt == 3'd0);
                    end else begin
                        state_nxt = SETTLE;
                        vec_nxt   = vec_idx + 2'd1;
                        cnt_nxt   = '0;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy           = (state == SETTLE) || (state == SAMPLE);
    assign done           = (state == DONE);
    assign {dut_a, dut_b} = busy ? vec_idx : 2'b00;
    assign pass           = res.pass;
    assign fail_mask      = res.fail_mask;
    assign err_cnt        = res.err_cnt;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Randomized bench for gate_bist_ctrl: a behavioural gate drives dut_y and the
// expected results are derived from the gate's truth table versus the reference.
module tb_gate_bist_ctrl;

    localparam logic [3:0] REF_TRUTH = 4'b1001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, abort, start0, start1;
    logic [3:0] gate_tt;

    logic       y0, a0, b0, busy0, done0, pass0;
    logic [3:0] fm0;
    logic [2:0] ec0;
    logic [1:0] vi0;
    logic       y1, a1, b1, busy1, done1, pass1;
    logic [3:0] fm1;
    logic [2:0] ec1;
    logic [1:0] vi1;

    assign y0 = gate_tt[{a0, b0}];
    assign y1 = gate_tt[{a1, b1}];

    gate_bist_ctrl #(.TRUTH(REF_TRUTH), .SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start0), .abort(abort), .dut_y(y0),
        .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(fm0), .err_cnt(ec0), .vec_idx(vi0)
    );

    gate_bist_ctrl #(.TRUTH(REF_TRUTH), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .dut_y(y1),
        .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(fm1), .err_cnt(ec1), .vec_idx(vi1)
    );

    int errors = 0;
    int checks = 0;
    int sel    = 0;

    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [3:0] o_fm;
    logic [2:0] o_ec;
    logic [1:0] o_vi;

    always_comb begin
        if (sel == 0) begin
            o_a = a0; o_b = b0; o_busy = busy0; o_done = done0; o_pass = pass0;
            o_fm = fm0; o_ec = ec0; o_vi = vi0;
        end else begin
            o_a = a1; o_b = b1; o_busy = busy1; o_done = done1; o_pass = pass1;
            o_fm = fm1; o_ec = ec1; o_vi = vi1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    // Full run: every cycle k after the start edge drives vector k/(S+1).
    task automatic test_run(input logic [3:0] tt, input int s, input string nm);
        logic [3:0] em;
        int per;
        gate_tt = tt;
        em  = tt ^ REF_TRUTH;
        per = s + 1;
        set_start(1'b1);
        step();
        set_start(1'b0);
        for (int k = 0; k < 4 * per; k++) begin
            checks++;
            if (o_busy !== 1'b1 || o_done !== 1'b0 || {o_a, o_b} !== 2'(k / per) || o_vi !== 2'(k / per)) begin
                errors++;
                $display("FAIL %s seq k=%0d: busy=%b done=%b ab=%b%b vec=%0d want busy=1 done=0 vec=%0d",
                         nm, k, o_busy, o_done, o_a, o_b, o_vi, k / per);
            end
            step();
        end
        checks++;
        if (o_done !== 1'b1 || o_pass !== (em == 4'd0) || o_fm !== em || o_ec !== 3'($countones(em))) begin
            errors++;
            $display("FAIL %s done: done=%b pass=%b mask=%b err=%0d want done=1 pass=%b mask=%b err=%0d",
                     nm, o_done, o_pass, o_fm, o_ec, (em == 4'd0), em, $countones(em));
        end
        step();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || {o_a, o_b} !== 2'b00 || o_fm !== em || o_pass !== (em == 4'd0)) begin
            errors++;
            $display("FAIL %s after: done=%b busy=%b ab=%b%b mask=%b pass=%b want 0 0 00 %b %b",
                     nm, o_done, o_busy, o_a, o_b, o_fm, o_pass, em, (em == 4'd0));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; abort = 1'b0; start0 = 1'b0; start1 = 1'b0; gate_tt = REF_TRUTH;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({a0, b0, busy0, done0, pass0, fm0, ec0, vi0} !== 15'd0 ||
            {a1, b1, busy1, done1, pass1, fm1, ec1, vi1} !== 15'd0) begin
            errors++;
            $display("FAIL reset: u0=%b u1=%b want all zero",
                     {a0, b0, busy0, done0, pass0, fm0, ec0, vi0},
                     {a1, b1, busy1, done1, pass1, fm1, ec1, vi1});
        end
    endtask

    task automatic test_stuck_restart();
        sel = 0;
        test_run(4'b0000, 2, "stuck0");
        test_run(REF_TRUTH, 2, "restart_good");
    endtask

    task automatic test_abort();
        logic [3:0] tt;
        int dones;
        sel = 0;
        tt = 4'($urandom_range(0, 15));
        gate_tt = tt;
        // start together with abort in IDLE is dropped
        start0 = 1'b1; abort = 1'b1;
        step();
        start0 = 1'b0; abort = 1'b0;
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_vs_start: busy=%b want 0", busy0);
        end
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 0; k < 6; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || {a0, b0} !== 2'b00 || done0 !== 1'b0 || pass0 !== 1'b0 ||
            fm0 !== ((tt ^ REF_TRUTH) & 4'b0011)) begin
            errors++;
            $display("FAIL abort: busy=%b ab=%b%b done=%b pass=%b mask=%b want 0 00 0 0 %b",
                     busy0, a0, b0, done0, pass0, fm0, (tt ^ REF_TRUTH) & 4'b0011);
        end
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            if (done0 === 1'b1) dones++;
            step();
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_nodone: dones=%0d want 0", dones);
        end
    endtask

    task automatic test_start_held();
        int dones;
        sel = 0;
        gate_tt = REF_TRUTH;
        dones = 0;
        start0 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (done0 === 1'b1) begin
                dones++;
                start0 = 1'b0;
            end
        end
        start0 = 1'b0;
        checks++;
        if (dones != 1 || pass0 !== 1'b1) begin
            errors++;
            $display("FAIL start_held: dones=%0d pass=%b want 1 1", dones, pass0);
        end
    endtask

    task automatic test_rst_mid();
        sel = 0;
        test_run(4'b1000, 2, "pre_rst");
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 0; k < 5; k++) step();
        // cycle 5: SAMPLE of vector 01
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({a0, b0, busy0, done0, pass0, fm0, ec0, vi0} !== 15'd0) begin
            errors++;
            $display("FAIL rst_mid: outs=%b want all zero", {a0, b0, busy0, done0, pass0, fm0, ec0, vi0});
        end
        test_run(REF_TRUTH, 2, "post_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 1));
            test_run(4'($urandom_range(0, 15)), (sel == 1) ? 1 : 2, "random");
        end
    endtask

    initial begin
        test_reset();
        sel = 0;
        test_run(REF_TRUTH, 2, "xnor_good");
        test_run(4'b1000, 2, "and_gate");
        test_stuck_restart();
        test_abort();
        test_start_held();
        test_rst_mid();
        sel = 1;
        test_run(REF_TRUTH, 1, "settle1");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
